uart_frame_tx: RTL and testbench
================================

Name: uart_frame_tx

Overview:
- Line-side UART transmitter: serializes bytes from a valid/ready stream onto an 8N1 serial line, LSB first.
- Drives a receiver's serial input, e.g. the host-emulation path feeding the SDU rxd during board bring-up, or the loopback path in benches.
- Includes a 16-deep byte FIFO so the DCP side can burst command/response strings without tracking bit timing.

Parameters:
- BAUD_DIV, 868, clock cycles per bit (100 MHz / 115200); must be >= 2.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16.

Ports:
- clk  in  1  system clock (dclk domain).
- rst  in  1  asynchronous active-high reset.
- d_tx  in  8  byte to send.
- vld_tx  in  1  d_tx valid.
- rdy_tx  out  1  FIFO can accept; equals !full.
- txd  out  1  serial line; idle high.
- busy  out  1  frame in progress or FIFO non-empty.
- fifo_cnt  out  FIFO_AW+1  current FIFO occupancy, 0..16.

Behaviour:
- Reset, applied asynchronously:
  - txd=1, busy=0, fifo_cnt=0, rdy_tx=1.
  - FSM goes to IDLE and the FIFO is emptied.
  - A frame in progress is aborted at once, with no stop bit; txd is high in the same instant.
- Handshake:
  - A byte is accepted on the posedge where vld_tx && rdy_tx.
  - A source holding vld_tx while rdy_tx=0 keeps d_tx stable; nothing is lost or duplicated.
- FIFO:
  - Synchronous, first-word fall-through.
  - A push and a pop on the same edge leave fifo_cnt unchanged.
  - Because rdy_tx=0 when full, no push can occur when full.
  - Pointers wrap modulo depth.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If FIFO is non-empty, pop into shift register, go to START on the same edge, and txd=0 from that edge.
  - START: holds for BAUD_DIV cycles, then goes to DATA with txd=bit0.
  - DATA: 8 bits, BAUD_DIV cycles each, shifting LSB first. A 3-bit bit counter moves to STOP after bit7.
  - STOP: txd=1 for BAUD_DIV cycles.
    - At the end of STOP, if FIFO is non-empty, pop and go straight to START with no idle gap (back-to-back frames).
    - Otherwise go to IDLE.
- Latency: a byte pushed into an empty FIFO idle at edge N starts its start bit at edge N+1. Frame length is exactly 10*BAUD_DIV cycles.
- Timing: baud counter counts 0..BAUD_DIV-1 and reloads to 0 on every state change. txd is registered, so there is no glitching.
- busy = (state != IDLE) || (fifo_cnt != 0).

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP}.
  - DATA_BITS=8.
  - Default BAUD_DIV constant, shared with uart_rx.
- Sub-module byte_fifo, parameterized by FIFO_AW:
  - Ports: push, pop, din, dout, full, empty, cnt.
- The FSM, baud counter and shift register stay in uart_frame_tx.

Test Plan:
- Single byte, BAUD_DIV=4: push 0x55 at edge 0 -> txd from edge 1 is 0 (4 cycles), then 1,0,1,0,1,0,1,0 (4 cycles each), then stop 1 (4 cycles). busy drops at edge 41.
- Burst fill, BAUD_DIV=4: vld_tx held high with bytes 0x00..0x10 from edge 0 -> 17 bytes accepted at edges 0..16. fifo_cnt=16 and rdy_tx=0 after edge 16. Serial output decodes to 0x00..0x10 in order, with no idle gap between frames.
- Backpressure: vld_tx high with 0xA3 while full -> not accepted until rdy_tx rises (one byte popped). Then accepted exactly once, and appears once on txd.
- Simultaneous push/pop: fifo_cnt=3, push on the same edge the FSM pops at the end of STOP -> fifo_cnt stays 3 and the next START follows immediately.
- Reset mid-frame: rst pulsed during DATA bit 3 of 0xF0 with 5 bytes queued -> txd=1 immediately, fifo_cnt=0, busy=0. The next byte pushed after release is sent as a clean full frame.
- Loopback: txd wired to uart_rx (same BAUD_DIV=16) with 0x00, 0xFF, 0x5A, 0x81 sent -> uart_rx vld_rx yields exactly those 4 bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width and default bit timing.
package uart_pkg;

  // Bits per character (8N1 framing).
  localparam int DATA_BITS = 8;

  // 100 MHz system clock / 115200 baud; shared with uart_rx.
  localparam int BAUD_DIV_DEFAULT = 868;

  // Transmit frame states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_frame_tx_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
  parameter int FIFO_AW = 4,
  parameter int DW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] cnt
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [DW-1:0]      r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_cnt;
  logic               w_push;
  logic               w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign full  = (r_cnt == (FIFO_AW+1)'(DEPTH));
  assign empty = (r_cnt == (FIFO_AW+1)'(0));
  assign cnt   = r_cnt;
  assign dout  = r_mem[r_rd_ptr];

  // Storage array: written on an accepted push, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally modulo depth; count tracks push/pop balance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= FIFO_AW'(0);
      r_rd_ptr <= FIFO_AW'(0);
      r_cnt    <= (FIFO_AW+1)'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (FIFO_AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (FIFO_AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// 8N1 UART transmitter fed by a valid/ready byte stream through a small FIFO.
// Frames go out LSB first; a queued byte follows a stop bit with no idle gap.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int FIFO_AW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       d_tx,
  input  logic             vld_tx,
  output logic             rdy_tx,
  output logic             txd,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_cnt
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_e          r_state;
  logic [BW-1:0]        r_baud_cnt;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_txd;

  logic                 w_full;
  logic                 w_empty;
  logic [7:0]           w_fifo_dout;
  logic                 w_baud_end;
  logic                 w_pop;

  assign w_baud_end = (r_baud_cnt == BAUD_LAST);

  // Pop when a new frame may start: from IDLE, or at the very end of STOP.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_end));

  byte_fifo #(
    .FIFO_AW (FIFO_AW),
    .DW      (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_tx),
    .pop   (w_pop),
    .din   (d_tx),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .cnt   (fifo_cnt)
  );

  assign rdy_tx = !w_full;
  assign txd    = r_txd;
  assign busy   = (r_state != ST_IDLE) || !w_empty;

  // Frame sequencer: baud counter restarts on every state change and txd is
  // updated on the same edge so each bit lasts exactly BAUD_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= BW'(0);
      r_bit_cnt  <= 3'd0;
      r_shift    <= {DATA_BITS{1'b0}};
      r_txd      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_baud_cnt <= BW'(0);
          r_bit_cnt  <= 3'd0;
          if (!w_empty) begin
            r_shift <= w_fifo_dout;
            r_state <= ST_START;
            r_txd   <= 1'b0;
          end else begin
            r_txd   <= 1'b1;
          end
        end
        ST_START: begin
          if (w_baud_end) begin
            r_state    <= ST_DATA;
            r_baud_cnt <= BW'(0);
            r_bit_cnt  <= 3'd0;
            r_txd      <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        ST_DATA: begin
          if (w_baud_end) begin
            r_baud_cnt <= BW'(0);
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
              r_txd     <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        ST_STOP: begin
          if (w_baud_end) begin
            r_baud_cnt <= BW'(0);
            r_bit_cnt  <= 3'd0;
            if (!w_empty) begin
              r_shift <= w_fifo_dout;
              r_state <= ST_START;
              r_txd   <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_txd   <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_baud_cnt <= BW'(0);
          r_bit_cnt  <= 3'd0;
          r_txd      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: accepted bytes go to a scoreboard
// queue, a serial decoder on txd pops and compares each received frame.
module tb_uart_frame_tx;

  localparam int BD = 4;
  localparam int FL = 10 * BD;

  logic       clk;
  logic       rst;
  logic [7:0] d_tx;
  logic       vld_tx;
  logic       rdy_tx;
  logic       txd;
  logic       busy;
  logic [4:0] fifo_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  int n_dec   = 0;
  int cyc     = 0;
  bit b2b_chk = 0;
  bit prev_valid = 0;
  logic [7:0] exp_q[$];

  uart_frame_tx #(.BAUD_DIV(BD), .FIFO_AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .d_tx     (d_tx),
    .vld_tx   (vld_tx),
    .rdy_tx   (rdy_tx),
    .txd      (txd),
    .busy     (busy),
    .fifo_cnt (fifo_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected txd level at position p (cycles from start-bit edge) of a frame.
  function automatic logic frame_bit(input logic [7:0] b, input int p);
    if (p < BD) return 1'b0;
    else if (p < 9 * BD) return b[(p - BD) / BD];
    else return 1'b1;
  endfunction

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard producer: record every byte the DUT accepts.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
      end else if (vld_tx && rdy_tx) begin
        exp_q.push_back(d_tx);
        acc_cnt++;
      end
    end
  end

  // Serial decoder: samples mid-bit on negedges, compares against scoreboard.
  initial begin
    bit         active;
    int         pos;
    int         start_t;
    int         prev_t;
    logic [7:0] sh;
    logic [7:0] e;
    active = 0; pos = 0; start_t = 0; prev_t = 0; sh = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        active = 0;
        prev_valid = 0;
      end else if (!active) begin
        if (txd == 1'b0) begin
          active  = 1;
          pos     = 0;
          start_t = cyc;
          if (b2b_chk && prev_valid)
            check_val("frame_gap", start_t - prev_t, FL);
        end
      end else begin
        pos++;
        if (pos == BD / 2) begin
          check_val("dec_start", {31'd0, txd}, 32'd0);
        end else if (pos % BD == BD / 2 && pos / BD <= 8) begin
          sh = {txd, sh[7:1]};
        end else if (pos == 9 * BD + BD / 2) begin
          check_val("dec_stop", {31'd0, txd}, 32'd1);
          if (exp_q.size() == 0) begin
            check_val("dec_extra", {24'd0, sh}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check_val("dec_byte", {24'd0, sh}, {24'd0, e});
          end
          n_dec++;
          prev_t     = start_t;
          prev_valid = 1;
          active     = 0;
        end
      end
    end
  end

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int waited;
    rst = 1'b1; vld_tx = 1'b0; d_tx = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_txd", {31'd0, txd}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_cnt", {27'd0, fifo_cnt}, 32'd0);
    check_val("rst_rdy", {31'd0, rdy_tx}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single byte 0x55: exact waveform.
    b2b_chk = 0;
    d_tx = 8'h55; vld_tx = 1'b1;
    @(posedge clk); #1;
    vld_tx = 1'b0;
    @(negedge clk);
    check_val("s_pre_txd", {31'd0, txd}, 32'd1);
    check_val("s_pre_busy", {31'd0, busy}, 32'd1);
    for (int p = 0; p < FL; p++) begin
      @(negedge clk);
      check_val("s_bit", {31'd0, txd}, {31'd0, frame_bit(8'h55, p)});
    end
    check_val("s_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_val("s_busy_drop", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Burst fill then backpressure with 0xA3.
    b2b_chk = 1; prev_valid = 0;
    a0 = acc_cnt;
    vld_tx = 1'b1;
    for (int i = 0; i < 17; i++) begin
      d_tx = 8'(i);
      @(posedge clk); #1;
    end
    check_val("b_acc17", acc_cnt - a0, 32'd17);
    check_val("b_cnt16", {27'd0, fifo_cnt}, 32'd16);
    check_val("b_rdy0", {31'd0, rdy_tx}, 32'd0);
    d_tx = 8'hA3;
    waited = 0;
    while (acc_cnt - a0 == 17 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    vld_tx = 1'b0;
    check_val("bp_accept", acc_cnt - a0, 32'd18);
    check_val("bp_blocked", {31'd0, waited > 1}, 32'd1);
    wait_idle(2000);

    // Push coincident with the end-of-STOP pop.
    b2b_chk = 1; prev_valid = 0;
    @(posedge clk); #1;
    vld_tx = 1'b1;
    d_tx = 8'h11; @(posedge clk); #1;
    d_tx = 8'h22; @(posedge clk); #1;
    d_tx = 8'h33; @(posedge clk); #1;
    d_tx = 8'h44; @(posedge clk); #1;
    vld_tx = 1'b0;
    check_val("pp_cnt3", {27'd0, fifo_cnt}, 32'd3);
    repeat (37) @(posedge clk);
    #1;
    check_val("pp_cnt_pre", {27'd0, fifo_cnt}, 32'd3);
    check_val("pp_stop", {31'd0, txd}, 32'd1);
    d_tx = 8'h3C; vld_tx = 1'b1;
    @(posedge clk); #1;
    vld_tx = 1'b0;
    check_val("pp_cnt_post", {27'd0, fifo_cnt}, 32'd3);
    check_val("pp_start", {31'd0, txd}, 32'd0);
    wait_idle(2000);

    // Reset during DATA bit 3 of 0xF0 with 5 bytes queued.
    b2b_chk = 0;
    @(posedge clk); #1;
    vld_tx = 1'b1;
    d_tx = 8'hF0; @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      d_tx = 8'(k); @(posedge clk); #1;
    end
    vld_tx = 1'b0;
    check_val("rm_cnt5", {27'd0, fifo_cnt}, 32'd5);
    repeat (13) @(posedge clk);
    #1;
    check_val("rm_bit3", {31'd0, txd}, 32'd0);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check_val("rm_txd", {31'd0, txd}, 32'd1);
    check_val("rm_cnt", {27'd0, fifo_cnt}, 32'd0);
    check_val("rm_busy", {31'd0, busy}, 32'd0);
    check_val("rm_rdy", {31'd0, rdy_tx}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    d_tx = 8'h96; vld_tx = 1'b1;
    @(posedge clk); #1;
    vld_tx = 1'b0;
    wait_idle(200);

    // Loopback pattern.
    b2b_chk = 1; prev_valid = 0;
    @(posedge clk); #1;
    vld_tx = 1'b1;
    d_tx = 8'h00; @(posedge clk); #1;
    d_tx = 8'hFF; @(posedge clk); #1;
    d_tx = 8'h5A; @(posedge clk); #1;
    d_tx = 8'h81; @(posedge clk); #1;
    vld_tx = 1'b0;
    wait_idle(400);
    @(negedge clk);

    check_val("sb_empty", exp_q.size(), 32'd0);
    check_val("dec_total", n_dec, 32'd29);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
